ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, resend 0xFE) from the MSX-side controller to the attached keyboard using the PS/2 request-to-send sequence, then checks the device ACK bit. It shares the open-collector PS/2 clock/data pins with the scancode receive path and holds that path off while a transfer runs.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_edge_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, keyboard command bytes and
// default cycle counts for a 16 MHz system clock.
package ps2_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_INHIBIT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_REQ      = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA     = 3'd3;
  localparam logic [STATE_W-1:0] ST_PARITY   = 3'd4;
  localparam logic [STATE_W-1:0] ST_ACK      = 3'd5;
  localparam logic [STATE_W-1:0] ST_WAITIDLE = 3'd6;

  localparam logic [7:0] CMD_LED    = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;

  // 120 us clock inhibit and 2 ms edge-gap limit at 16 MHz
  localparam int DEF_INHIBIT_CYCLES = 1920;
  localparam int DEF_TIMEOUT_CYCLES = 32000;

  // Odd parity bit for a PS/2 frame: set when the byte has an even number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Brings the raw PS/2 clock and data pins into the system clock domain and
// flags falling edges of the PS/2 clock. Shared with the receive path.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall_edge
);

  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1;

  // Two synchronizer stages per pin plus a history stage on the clock; reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= clk_pin;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= dat_pin;
      dat_p1 <= dat_p0;
    end
  end

  assign clk_sync  = clk_p1;
  assign dat_sync  = dat_p1;
  assign fall_edge = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocks out one command
// byte on device-generated falling edges, then checks the device ACK bit.
// Holds the receive path off (rxInhibit) while a transfer is in flight.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       rxInhibit,
  output logic       done,
  output logic       ackErr,
  output logic       timeoutErr,
  input  logic       ps2ClkIn,
  input  logic       ps2DatIn,
  output logic       ps2ClkOe,
  output logic       ps2DatOe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [7:0]         shift_q;
  logic               parity_q;
  logic [3:0]         bit_cnt;
  logic [INH_W-1:0]   inh_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic clk_sync, dat_sync, fall_edge;
  logic accept, counting, timeout, fall_act, enter_req, shift_en, bus_idle;
  logic clk_oe_nxt, dat_oe_nxt, busy_nxt, done_nxt, ack_err_nxt, to_err_nxt;

  ps2_edge_sync u_sync (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clk_pin   (ps2ClkIn),
    .dat_pin   (ps2DatIn),
    .clk_sync  (clk_sync),
    .dat_sync  (dat_sync),
    .fall_edge (fall_edge)
  );

  // A request landing on a completion-pulse cycle is dropped; the caller retries
  assign accept    = (state == ST_IDLE) && txStart && !done && !ackErr && !timeoutErr;
  assign counting  = (state == ST_REQ) || (state == ST_DATA) || (state == ST_PARITY) ||
                     (state == ST_ACK) || (state == ST_WAITIDLE);
  assign timeout   = counting && (int'(to_cnt) == TIMEOUT_CYCLES - 1);
  // Timeout wins over an edge arriving in the same cycle
  assign fall_act  = fall_edge && !timeout;
  assign enter_req = (state_nxt == ST_REQ) && (state != ST_REQ);
  assign shift_en  = fall_act && ((state == ST_REQ) || ((state == ST_DATA) && (bit_cnt != 4'd7)));
  assign bus_idle  = clk_sync && dat_sync;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (accept) state_nxt = ST_INHIBIT;
        ST_INHIBIT:  if (int'(inh_cnt) == INHIBIT_CYCLES - 1) state_nxt = ST_REQ;
        ST_REQ:      if (fall_edge) state_nxt = ST_DATA;
        ST_DATA:     if (fall_edge && (bit_cnt == 4'd7)) state_nxt = ST_PARITY;
        ST_PARITY:   if (fall_edge) state_nxt = ST_ACK;
        ST_ACK:      if (fall_edge) state_nxt = dat_sync ? ST_IDLE : ST_WAITIDLE;
        ST_WAITIDLE: if (bus_idle) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; pins hold unless an event changes them
  always_comb begin
    clk_oe_nxt  = ps2ClkOe;
    dat_oe_nxt  = ps2DatOe;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ack_err_nxt = 1'b0;
    to_err_nxt  = 1'b0;
    if (timeout) begin
      clk_oe_nxt = 1'b0;
      dat_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      to_err_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            clk_oe_nxt = 1'b1;
            dat_oe_nxt = 1'b0;
            busy_nxt   = 1'b1;
          end
        end
        ST_INHIBIT: begin
          // Data goes low one cycle before the clock is let go
          if (int'(inh_cnt) >= INHIBIT_CYCLES - 2) dat_oe_nxt = 1'b1;
          if (int'(inh_cnt) == INHIBIT_CYCLES - 1) clk_oe_nxt = 1'b0;
        end
        ST_REQ: begin
          if (fall_edge) dat_oe_nxt = ~shift_q[0];
        end
        ST_DATA: begin
          if (fall_edge) dat_oe_nxt = (bit_cnt == 4'd7) ? ~parity_q : ~shift_q[0];
        end
        ST_PARITY: begin
          if (fall_edge) dat_oe_nxt = 1'b0;
        end
        ST_ACK: begin
          if (fall_edge && dat_sync) begin
            ack_err_nxt = 1'b1;
            busy_nxt    = 1'b0;
          end
        end
        ST_WAITIDLE: begin
          if (bus_idle) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end
        end
        default: begin
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Output registers; reset releases both pins without waiting for a clock
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ps2ClkOe   <= 1'b0;
      ps2DatOe   <= 1'b0;
      busy       <= 1'b0;
      rxInhibit  <= 1'b0;
      done       <= 1'b0;
      ackErr     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      ps2ClkOe   <= clk_oe_nxt;
      ps2DatOe   <= dat_oe_nxt;
      busy       <= busy_nxt;
      rxInhibit  <= busy_nxt;
      done       <= done_nxt;
      ackErr     <= ack_err_nxt;
      timeoutErr <= to_err_nxt;
    end
  end

  // Inhibit, bit and edge-gap counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inh_cnt <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (accept)                  inh_cnt <= '0;
      else if (state == ST_INHIBIT) inh_cnt <= inh_cnt + INH_W'(1);

      if ((state == ST_REQ) && fall_act)
        bit_cnt <= '0;
      else if ((state == ST_DATA) && fall_act && (bit_cnt != 4'd7))
        bit_cnt <= bit_cnt + 4'd1;

      if (enter_req || fall_edge) to_cnt <= '0;
      else if (counting)          to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Command byte and parity captured at accept; byte shifts out LSB first
  always_ff @(posedge CLK) begin
    if (accept) begin
      shift_q  <= txData;
      parity_q <= odd_parity(txData);
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Expected frame bits are queued when a command is issued and popped as the
// device model samples the data line on each rising clock edge.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 1920;
  localparam int TIMEOUT = 2000;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txStart = 1'b0;
  logic       busy, rxInhibit, done, ackErr, timeoutErr;
  logic       ps2ClkOe, ps2DatOe;
  logic       dev_clk_pull = 1'b0;
  logic       dev_dat_pull = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2ClkOe | dev_clk_pull);
  assign dat_line = ~(ps2DatOe | dev_dat_pull);

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .txData     (txData),
    .txStart    (txStart),
    .busy       (busy),
    .rxInhibit  (rxInhibit),
    .done       (done),
    .ackErr     (ackErr),
    .timeoutErr (timeoutErr),
    .ps2ClkIn   (clk_line),
    .ps2DatIn   (dat_line),
    .ps2ClkOe   (ps2ClkOe),
    .ps2DatOe   (ps2DatOe)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge of CLK
  int done_hi = 0, ack_hi = 0, to_hi = 0, pulse_busy_bad = 0;
  int clk_oe_rise = 0, clk_oe_fall = 0, dat_inh_rise = 0, dat_oe_chg = 0;
  int line_fall = 0, to_cyc = 0;
  logic [1:0] to_oe = 2'b00;
  logic clk_oe_prev = 1'b0, dat_oe_prev = 1'b0, clk_line_prev = 1'b1;
  always @(negedge CLK) begin
    if (done) done_hi++;
    if (ackErr) ack_hi++;
    if (timeoutErr) begin
      to_hi++;
      to_cyc = cyc;
      to_oe  = {ps2ClkOe, ps2DatOe};
    end
    if ((done || ackErr || timeoutErr) && busy) pulse_busy_bad++;
    if (ps2ClkOe && !clk_oe_prev) clk_oe_rise = cyc;
    if (!ps2ClkOe && clk_oe_prev) clk_oe_fall = cyc;
    if (ps2DatOe && !dat_oe_prev && ps2ClkOe) dat_inh_rise = cyc;
    if (ps2DatOe !== dat_oe_prev) dat_oe_chg = cyc;
    if (!clk_line && clk_line_prev) line_fall = cyc;
    clk_oe_prev   = ps2ClkOe;
    dat_oe_prev   = ps2DatOe;
    clk_line_prev = clk_line;
  end

  int checks = 0, errors = 0;
  bit exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      if (b[i]) ones++;
    end
    exp_q.push_back(((ones % 2) == 0) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
  endtask

  task automatic pop_cmp(input int idx, input logic obs);
    if (exp_q.size() == 0) begin
      check($sformatf("frame_bit%0d_queue_empty", idx), 1, 0);
    end else begin
      bit e = exp_q.pop_front();
      check($sformatf("frame_bit%0d", idx), int'(obs), int'(e));
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge CLK);
    #1 txData = d;
    txStart = 1'b1;
    push_frame(d);
    @(posedge CLK);
    #1 txStart = 1'b0;
  endtask

  // Device model: waits for the host to release the clock, then generates
  // n_falls clock pulses, reading data on each rising edge.
  task automatic device(input int half, input int n_falls, input bit ack_low, input bit chk_lat);
    int w = 0;
    while (!ps2ClkOe && w < 5000) begin @(posedge CLK); w++; end
    w = 0;
    while (ps2ClkOe && w < 5000) begin @(posedge CLK); w++; end
    check("clk_release_wait_expired", int'(w >= 5000), 0);
    #1 pop_cmp(0, dat_line);
    repeat (half) @(posedge CLK);
    for (int i = 1; i <= n_falls; i++) begin
      #1 dev_clk_pull = 1'b1;
      repeat (half) @(posedge CLK);
      if (i == 1 && chk_lat) check("fall_to_dat_oe_latency", dat_oe_chg - line_fall, 3);
      #1 dev_clk_pull = 1'b0;
      if (i <= 10) pop_cmp(i, dat_line);
      if (i == 10 && ack_low) dev_dat_pull = 1'b1;
      if (i == 11) dev_dat_pull = 1'b0;
      repeat (half) @(posedge CLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, a0, t0, r0, w;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_clk_oe", ps2ClkOe, 0);
    check("reset_dat_oe", ps2DatOe, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_inhibit", rxInhibit, 0);
    check("reset_done", done, 0);
    check("reset_ack_err", ackErr, 0);
    check("reset_timeout_err", timeoutErr, 0);
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);

    // 0xED at 12.5 kHz, second request during inhibit must be ignored
    d0 = done_hi;
    send(CMD_LED);
    check("busy_after_accept", busy, 1);
    check("rx_inhibit_follows_busy", rxInhibit, 1);
    @(posedge CLK);
    #1 txData = 8'h55;
    txStart = 1'b1;
    @(posedge CLK);
    #1 txStart = 1'b0;
    device(640, 11, 1'b1, 1'b1);
    repeat (10) @(posedge CLK);
    #1;
    check("inhibit_width", clk_oe_fall - clk_oe_rise, INHIBIT);
    check("dat_low_before_clk_release",
          int'(dat_inh_rise > clk_oe_rise && dat_inh_rise < clk_oe_fall), 1);
    check("led_done_pulses", done_hi - d0, 1);
    check("led_busy_after", busy, 0);
    check("led_queue_drained", exp_q.size(), 0);

    // 0xF4: parity 0
    d0 = done_hi;
    send(CMD_ENABLE);
    device(50, 11, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check("enable_done_pulses", done_hi - d0, 1);
    check("enable_busy_after", busy, 0);

    // 0x00: parity 1
    d0 = done_hi;
    send(8'h00);
    device(50, 11, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check("zero_done_pulses", done_hi - d0, 1);

    // ACK left high by the device
    d0 = done_hi;
    a0 = ack_hi;
    send(CMD_RESEND);
    device(50, 11, 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check("nack_ack_err_width", ack_hi - a0, 1);
    check("nack_no_done", done_hi - d0, 0);
    check("nack_clk_oe", ps2ClkOe, 0);
    check("nack_dat_oe", ps2DatOe, 0);
    check("nack_busy", busy, 0);

    // Device stops clocking after bit 3
    t0 = to_hi;
    d0 = done_hi;
    send(CMD_ENABLE);
    device(50, 4, 1'b0, 1'b0);
    w = 0;
    while (to_hi == t0 && w < TIMEOUT + 200) begin @(posedge CLK); w++; end
    repeat (5) @(posedge CLK);
    #1;
    check("timeout_pulse_width", to_hi - t0, 1);
    check("timeout_delay_from_last_fall", to_cyc - line_fall, TIMEOUT + 3);
    check("timeout_pins_released", int'(to_oe), 0);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", done_hi - d0, 0);
    exp_q.delete();

    check("completion_pulse_with_busy", pulse_busy_bad, 0);

    // Asynchronous reset during DATA
    send(8'h5A);
    device(50, 3, 1'b0, 1'b0);
    check("busy_before_reset", busy, 1);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    check("async_reset_clk_oe", ps2ClkOe, 0);
    check("async_reset_dat_oe", ps2DatOe, 0);
    check("async_reset_busy", busy, 0);
    #3 RST_N = 1'b1;
    exp_q.delete();
    r0 = clk_oe_rise;
    repeat (100) @(posedge CLK);
    #1;
    check("post_reset_idle_no_clk_oe", clk_oe_rise - r0, 0);
    check("post_reset_dat_oe", ps2DatOe, 0);
    check("post_reset_busy", busy, 0);

    // Fresh 0xFF after reset completes normally
    d0 = done_hi;
    send(CMD_RESET);
    device(50, 11, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check("reset_cmd_done_pulses", done_hi - d0, 1);
    check("reset_cmd_busy_after", busy, 0);
    check("reset_cmd_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
